map_bank_selector: RTL
======================

// Module: map_bank_selector
// PURPOSE
// - N-way background-map selector for the shooter's pixel pipeline. Generalises the 2-map select.
// - Drives one shared ROM address to NUM_MAPS external map ROMs and muxes their pixel data.
// - Map changes go through a request handshake. They commit only on a frame boundary, so a frame is never torn.
// - The select path is delayed to match ROM latency. The output pixel is registered and carries a valid flag.
// PARAMETERS
// - NUM_MAPS     4          number of map ROMs (2..16)
// - ADDR_W       16         ROM address width
// - DATA_W       24         pixel width (RGB888)
// - ROM_LAT      1          ROM read latency in clocks (1..4)
// - DEFAULT_MAP  0          map active after reset
// - BLANK_COLOR  24'h000000 pixel forced during blanking (MAP_BLANK_EN only)
// - BLANK_FRAMES 1          frames blanked after a switch (MAP_BLANK_EN only, 1..15)
// PORTS
// - clock          in  1                 system clock
// - reset_n        in  1                 asynchronous, active-low reset
// - address        in  ADDR_W            pixel address from the draw logic
// - addr_valid     in  1                 address is a real pixel this cycle
// - frame_start    in  1                 one-cycle pulse at the start of each frame (vsync edge)
// - map_req        in  $clog2(NUM_MAPS)  requested map index
// - map_req_valid  in  1                 request strobe
// - map_req_ready  out 1                 request can be accepted
// - rom_address    out ADDR_W            broadcast to all ROMs; equals address (combinational)
// - rom_q          in  NUM_MAPS*DATA_W   ROM data; map k is at [k*DATA_W +: DATA_W]
// - q              out DATA_W            selected pixel
// - q_valid        out 1                 q is valid
// - active_map     out $clog2(NUM_MAPS)  map currently displayed
// - switch_done    out 1                 one-cycle pulse when a pending switch commits
// - req_error      out 1                 one-cycle pulse when a request index is >= NUM_MAPS
// BEHAVIOUR
// - Reset: active_map=DEFAULT_MAP; pending cleared; q=0; q_valid=0; switch_done=0; req_error=0.
// - Handshake:
//   - map_req_ready = !pending.
//   - A request is accepted when map_req_valid && map_req_ready && map_req<NUM_MAPS. It sets pending and latches next_map.
//   - Out-of-range index: req_error pulses on the next cycle; no state change.
//   - map_req_valid while not ready is ignored; the requester holds or retries.
// - Commit:
//   - On frame_start with pending set: active_map<=next_map, pending cleared, switch_done pulses in the same registered cycle.
//   - A request accepted in the same cycle as frame_start does not commit on that pulse. It waits for the next frame_start.
//   - A request equal to active_map still goes through pending/commit and pulses switch_done.
// - Datapath:
//   - sel_pipe and valid_pipe are ROM_LAT stages deep, loaded with {active_map, addr_valid} each cycle.
//   - q <= rom_q[sel_pipe_out]; q_valid <= valid_pipe_out.
//   - Latency from address/addr_valid to q/q_valid is ROM_LAT+1 clocks.
//   - Pixels already in flight when a commit happens keep their old map, because the select is tagged per pixel.
// - States (pending FSM):
//   - IDLE -> PEND on an accepted request.
//   - PEND -> IDLE on frame_start.
//   - reset_n low -> IDLE from any state, clearing the pipelines immediately (asynchronous).
// CONFIGURATION
// - MAP_BLANK_EN defined:
//   - On commit, load blank_cnt=BLANK_FRAMES.
//   - Each later frame_start decrements blank_cnt, saturating at 0.
//   - While blank_cnt!=0, q=BLANK_COLOR; q_valid is unchanged.
//   - The blank flag is pipelined alongside sel_pipe so blanking aligns exactly to frame pixels.
// - MAP_BLANK_EN undefined: no counter and no blanking logic; q is always the ROM data.
// TESTING
// - Reset: reset_n=0 mid-stream -> q=0, q_valid=0, active_map=DEFAULT_MAP, map_req_ready=1 immediately.
// - Latency: ROM_LAT=2, addr_valid=1 at cycle t, rom_q map0=24'hFF0000 -> q=24'hFF0000, q_valid=1 at t+3.
// - Switch: req map 2 mid-frame -> ready=0; active_map stays 0 until frame_start -> active_map=2, switch_done=1 for 1 clock.
// - Same-cycle: req map 3 coincident with frame_start -> no commit; commits on the following frame_start.
// - Error: NUM_MAPS=3, map_req=3, valid=1 -> req_error pulse; ready stays 1; active_map unchanged.
// - MAP_BLANK_EN, BLANK_FRAMES=2: after commit, the next 2 frames output 24'h000000; the third frame shows new-map data.

Source files
------------

// File: rtl/map_bank_selector.sv
// N-way background-map selector: one broadcast ROM address, per-pixel tagged select, frame-aligned map switching.
// Optional MAP_BLANK_EN: blanks BLANK_FRAMES frames to BLANK_COLOR after each committed switch.
module map_bank_selector #(
    parameter int                NUM_MAPS     = 4,
    parameter int                ADDR_W       = 16,
    parameter int                DATA_W       = 24,
    parameter int                ROM_LAT      = 1,
    parameter int                DEFAULT_MAP  = 0,
    parameter logic [DATA_W-1:0] BLANK_COLOR  = '0,
    parameter int                BLANK_FRAMES = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [ADDR_W-1:0]            address,
    input  logic                         addr_valid,
    input  logic                         frame_start,
    input  logic [$clog2(NUM_MAPS)-1:0]  map_req,
    input  logic                         map_req_valid,
    output logic                         map_req_ready,
    output logic [ADDR_W-1:0]            rom_address,
    input  logic [NUM_MAPS*DATA_W-1:0]   rom_q,
    output logic [DATA_W-1:0]            q,
    output logic                         q_valid,
    output logic [$clog2(NUM_MAPS)-1:0]  active_map,
    output logic                         switch_done,
    output logic                         req_error
);
    localparam int               SEL_W       = $clog2(NUM_MAPS);
    localparam logic [SEL_W:0]   NUM_MAPS_L  = (SEL_W+1)'(NUM_MAPS);
    localparam logic [SEL_W-1:0] DEFAULT_SEL = SEL_W'(DEFAULT_MAP);

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  active_map_q, active_map_d;
    logic [SEL_W-1:0]  next_map_q, next_map_d;
    logic              switch_done_q, switch_done_d;
    logic              req_error_q, req_error_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              q_valid_q, q_valid_d;
    logic [SEL_W-1:0]  sel_pipe_q [ROM_LAT];
    logic [SEL_W-1:0]  sel_pipe_d [ROM_LAT];
    logic              valid_pipe_q [ROM_LAT];
    logic              valid_pipe_d [ROM_LAT];
    logic              req_in_range;
    logic [DATA_W-1:0] rom_pixel;

    assign req_in_range  = {1'b0, map_req} < NUM_MAPS_L;
    assign map_req_ready = (state_q == IDLE);
    assign rom_address   = address;
    assign q             = q_q;
    assign q_valid       = q_valid_q;
    assign active_map    = active_map_q;
    assign switch_done   = switch_done_q;
    assign req_error     = req_error_q;

    // Requests are only looked at while ready; a commit needs a frame_start seen while already pending.
    always_comb begin
        state_d       = state_q;
        active_map_d  = active_map_q;
        next_map_d    = next_map_q;
        switch_done_d = 1'b0;
        req_error_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (map_req_valid) begin
                    if (req_in_range) begin
                        state_d    = PEND;
                        next_map_d = map_req;
                    end else begin
                        req_error_d = 1'b1;
                    end
                end
            end
            PEND: begin
                if (frame_start) begin
                    state_d       = IDLE;
                    active_map_d  = next_map_q;
                    switch_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Each pixel carries the map that was active when its address was issued.
    always_comb begin
        sel_pipe_d[0]   = active_map_q;
        valid_pipe_d[0] = addr_valid;
        for (int i = 1; i < ROM_LAT; i++) begin
            sel_pipe_d[i]   = sel_pipe_q[i-1];
            valid_pipe_d[i] = valid_pipe_q[i-1];
        end
        q_valid_d = valid_pipe_q[ROM_LAT-1];
    end

    assign rom_pixel = rom_q[int'(sel_pipe_q[ROM_LAT-1])*DATA_W +: DATA_W];

`ifdef MAP_BLANK_EN
    logic [3:0] blank_cnt_q, blank_cnt_d;
    logic       blank_pipe_q [ROM_LAT];
    logic       blank_pipe_d [ROM_LAT];

    always_comb begin
        blank_cnt_d = blank_cnt_q;
        if (switch_done_d) begin
            blank_cnt_d = 4'(BLANK_FRAMES);
        end else if (frame_start && (blank_cnt_q != 4'd0)) begin
            blank_cnt_d = blank_cnt_q - 4'd1;
        end
        blank_pipe_d[0] = (blank_cnt_q != 4'd0);
        for (int i = 1; i < ROM_LAT; i++) begin
            blank_pipe_d[i] = blank_pipe_q[i-1];
        end
        q_d = blank_pipe_q[ROM_LAT-1] ? BLANK_COLOR : rom_pixel;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blank_cnt_q <= 4'd0;
            for (int i = 0; i < ROM_LAT; i++) begin
                blank_pipe_q[i] <= 1'b0;
            end
        end else begin
            blank_cnt_q <= blank_cnt_d;
            for (int i = 0; i < ROM_LAT; i++) begin
                blank_pipe_q[i] <= blank_pipe_d[i];
            end
        end
    end
`else
    logic cfg_unused;
    assign cfg_unused = ^{BLANK_COLOR, 4'(BLANK_FRAMES)};
    assign q_d        = rom_pixel;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            active_map_q  <= DEFAULT_SEL;
            next_map_q    <= '0;
            switch_done_q <= 1'b0;
            req_error_q   <= 1'b0;
            q_q           <= '0;
            q_valid_q     <= 1'b0;
            for (int i = 0; i < ROM_LAT; i++) begin
                sel_pipe_q[i]   <= '0;
                valid_pipe_q[i] <= 1'b0;
            end
        end else begin
            state_q       <= state_d;
            active_map_q  <= active_map_d;
            next_map_q    <= next_map_d;
            switch_done_q <= switch_done_d;
            req_error_q   <= req_error_d;
            q_q           <= q_d;
            q_valid_q     <= q_valid_d;
            for (int i = 0; i < ROM_LAT; i++) begin
                sel_pipe_q[i]   <= sel_pipe_d[i];
                valid_pipe_q[i] <= valid_pipe_d[i];
            end
        end
    end

endmodule
